spi_target_core: RTL and testbench
==================================

SPI_TARGET_CORE -- requirements
Module: spi_target_core

Interface
REQ-001 Parameter WIDTH, default 32: frame length in bits; legal range 8..64.
REQ-002 Parameter CPOL, default 0: SCK idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 first on both lines, 0 = bit 0 first.
REQ-005 clk  input  1  system clock; every flop in the block SHALL be clocked by clk.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 spi_sclk  input  1  SPI clock from controller, asynchronous to clk.
REQ-008 spi_cs_n  input  1  chip select, active-low, asynchronous.
REQ-009 spi_mosi  input  1  controller-to-device data, asynchronous.
REQ-010 spi_miso  output  1  device-to-controller data.
REQ-011 tx_data  input  WIDTH  word to send; accepted when tx_valid & tx_ready.
REQ-012 tx_valid  input  1  tx_data valid.
REQ-013 tx_ready  output  1  high while the TX holding register is empty.
REQ-014 rx_data  output  WIDTH  last complete received word; held until the next complete frame.
REQ-015 rx_valid  output  1  single-cycle pulse when rx_data updates.
REQ-016 busy  output  1  high while state is SHIFT.
REQ-017 underrun  output  1  single-cycle pulse when a word starts with the holding register empty.
REQ-018 abort  output  1  single-cycle pulse when CS deasserts with a partial word.

Function
REQ-019 spi_sclk, spi_cs_n and spi_mosi SHALL each pass a 2-flop synchroniser; SCK edges SHALL be detected from the synchronised value and its previous copy. SCK frequency SHALL be at most clk/8.
REQ-020 Leading edge: rising if CPOL=0, falling if CPOL=1. Sample edge: leading if CPHA=0, else trailing. Shift edge: the other edge.
REQ-021 States: IDLE (synchronised CS high) and SHIFT (synchronised CS low). IDLE->SHIFT on synchronised CS fall. SHIFT->IDLE on synchronised CS rise.
REQ-022 Word load: on IDLE->SHIFT and at every word boundary, holding -> TX shift register, holding marked empty, bit counter cleared.
REQ-023 Word load with the holding register empty: shift register loaded with 0, underrun pulses in the same cycle.
REQ-024 CPHA=0: spi_miso SHALL present the first bit in the cycle after the word load; each shift edge advances one bit.
REQ-025 CPHA=1: the first shift edge of a word presents its first bit; each subsequent shift edge advances one bit.
REQ-026 Sample edge: synchronised mosi shifts into the RX shift register in MSB_FIRST order, and the bit counter increments modulo WIDTH.
REQ-027 When the counter wraps after WIDTH samples: rx_data <= RX shift register and rx_valid pulses, one clk after the edge-detect cycle. The next word loads immediately (REQ-022), so back-to-back words within one CS assertion are continuous.
REQ-028 Holding write: tx_valid & tx_ready loads holding and tx_ready falls in the next cycle.
REQ-029 Write coinciding with a word load into an empty holding register: the load sees the register empty (REQ-023), and the written word is kept for the following word.
REQ-030 CS rise with the counter not 0: abort pulses, the partial RX word is discarded (no rx_valid), the TX shift contents are dropped, and the holding register is retained.
REQ-031 CS rise with the counter at 0: no abort pulse.
REQ-032 SCK edges in IDLE SHALL be ignored.
REQ-033 spi_miso SHALL be 0 in IDLE. No tristate output.
REQ-034 Pulses (rx_valid, underrun, abort) SHALL never last more than one clk cycle.

Reset
REQ-035 While rst is high, and after its release: state IDLE, all shift registers 0, counter 0, holding empty, synchronisers at their inactive values (CS high, SCK = CPOL).
REQ-036 Output values under reset: spi_miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, abort=0.
REQ-037 Reset asserted mid-frame SHALL discard all partial data. The first frame after reset begins only on a fresh CS fall.

Verification
REQ-038 Mode 0, WIDTH=32: preload tx_data=0xA5A5_0F0F, controller sends 0x1234_5678 -> controller receives 0xA5A5_0F0F, rx_data=0x1234_5678, exactly one rx_valid.
REQ-039 Modes 1, 2 and 3, WIDTH=8: preload 0x3C, controller sends 0xC3 -> miso yields 0x3C and rx_data=0xC3 in each mode; MSB_FIRST=0 yields the bit-reversed sequence on the wires.
REQ-040 Two 32-bit words under one CS: holding refilled with 0xDEAD_BEEF after the first load -> second word out is 0xDEAD_BEEF, two rx_valid pulses, no underrun.
REQ-041 CS low with no preload -> underrun pulse at frame start, miso all zeros, rx still captured correctly.
REQ-042 CS raised after 13 of 32 bits -> abort pulse, no rx_valid, rx_data unchanged. Next full frame is correct.
REQ-043 rst pulsed after bit 20 -> outputs at REQ-036 values. The following frame completes correctly.

Source files
------------

// File: rtl/spi_target_core.sv
// rtl/spi_target_core.sv - SPI target (slave) core with TX holding register and RX word output
//
// Purpose:
//   Receives and transmits WIDTH-bit words over SPI while chip select is low.
//   All SPI pins are synchronised into clk and every flop runs on clk.
//   Words run back to back within one chip-select assertion.
//
// Parameters:
//   WIDTH      frame length in bits (8..64)
//   CPOL       SCK idle level
//   CPHA       0 = sample on leading edge, 1 = sample on trailing edge
//   MSB_FIRST  1 = bit WIDTH-1 first on both lines, 0 = bit 0 first
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_sclk/cs_n/mosi  SPI inputs from the controller (asynchronous to clk)
//   spi_miso            SPI data to the controller, 0 while idle
//   tx_data/valid/ready write port of the TX holding register
//   rx_data/rx_valid    last complete received word and its update pulse
//   busy                high while a frame is in progress
//   underrun            pulse when a word starts with no TX data available
//   abort               pulse when chip select ends a partial word

module spi_target_core #(
   parameter int WIDTH     = 32,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             underrun,
   output logic             abort
);

   localparam int   CW       = $clog2(WIDTH);
   localparam logic SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // synchronisers
   logic r_sck_s1, r_sck_s2, r_sck_prev;
   logic r_cs_s1, r_cs_s2;
   logic r_mosi_s1, r_mosi_s2;
   logic [1:0] r_sync_fill;
   logic r_cs_armed;

   // datapath
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_valid;
   logic [WIDTH-1:0] r_tx_shift;
   logic [WIDTH-1:0] r_rx_shift;
   logic [WIDTH-1:0] r_rx_data;
   logic [CW-1:0]    r_bit_cnt;
   logic             r_tx_armed;
   logic             r_wrap_d;
   logic             r_rx_valid;
   logic             r_abort;
   logic             r_ur_pend;

   logic w_sck_rise, w_sck_fall;
   logic w_lead, w_trail, w_sample, w_shift;
   logic w_start, w_end, w_in_shift;
   logic w_do_sample, w_wrap, w_load, w_hold_wr;
   logic [WIDTH-1:0] w_rx_nxt;
   logic [WIDTH-1:0] w_tx_adv;
   logic w_tx_bit;

   // Two-flop synchronisers. Reset values are the inactive pin levels so
   // no false SCK edge or CS fall is seen when reset releases.
   // r_sync_fill marks when r_cs_s2 holds a real pin sample; CS must be seen
   // high after that before a frame may start, so a CS that was already low
   // across reset cannot begin a frame mid-way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_s1    <= SCK_IDLE;
         r_sck_s2    <= SCK_IDLE;
         r_sck_prev  <= SCK_IDLE;
         r_cs_s1     <= 1'b1;
         r_cs_s2     <= 1'b1;
         r_mosi_s1   <= 1'b0;
         r_mosi_s2   <= 1'b0;
         r_sync_fill <= 2'b00;
         r_cs_armed  <= 1'b0;
      end else begin
         r_sck_s1    <= spi_sclk;
         r_sck_s2    <= r_sck_s1;
         r_sck_prev  <= r_sck_s2;
         r_cs_s1     <= spi_cs_n;
         r_cs_s2     <= r_cs_s1;
         r_mosi_s1   <= spi_mosi;
         r_mosi_s2   <= r_mosi_s1;
         r_sync_fill <= {r_sync_fill[0], 1'b1};
         r_cs_armed  <= r_cs_armed | (r_sync_fill[1] & r_cs_s2);
      end
   end

   assign w_sck_rise = r_sck_s2 & ~r_sck_prev;
   assign w_sck_fall = ~r_sck_s2 & r_sck_prev;
   assign w_lead     = (CPOL != 0) ? w_sck_fall : w_sck_rise;
   assign w_trail    = (CPOL != 0) ? w_sck_rise : w_sck_fall;
   assign w_sample   = (CPHA != 0) ? w_trail : w_lead;
   assign w_shift    = (CPHA != 0) ? w_lead  : w_trail;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_end       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_cs_armed && !r_cs_s2) begin
               w_state_nxt = ST_SHIFT;
               w_start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (r_cs_s2) begin
               w_state_nxt = ST_IDLE;
               w_end       = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // SCK edges only count while a frame is active and not ending this cycle
   assign w_in_shift  = (r_state == ST_SHIFT) && !r_cs_s2;
   assign w_do_sample = w_in_shift & w_sample;
   assign w_wrap      = w_do_sample && (r_bit_cnt == CW'(WIDTH - 1));
   assign w_load      = w_start | w_wrap;
   assign w_hold_wr   = tx_valid & ~r_hold_valid;

   assign w_rx_nxt = (MSB_FIRST != 0) ? {r_rx_shift[WIDTH-2:0], r_mosi_s2}
                                      : {r_mosi_s2, r_rx_shift[WIDTH-1:1]};
   assign w_tx_adv = (MSB_FIRST != 0) ? {r_tx_shift[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_tx_shift[WIDTH-1:1]};
   assign w_tx_bit = (MSB_FIRST != 0) ? r_tx_shift[WIDTH-1] : r_tx_shift[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_tx_shift   <= '0;
         r_rx_shift   <= '0;
         r_rx_data    <= '0;
         r_bit_cnt    <= '0;
         r_tx_armed   <= 1'b0;
         r_wrap_d     <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_abort      <= 1'b0;
         r_ur_pend    <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_abort    <= 1'b0;
         r_wrap_d   <= w_wrap;

         // A write in the same cycle as a load lands after the load has
         // already taken the (empty) register, so it serves the next word.
         if (w_hold_wr) begin
            r_hold       <= tx_data;
            r_hold_valid <= 1'b1;
         end else if (w_load) begin
            r_hold_valid <= 1'b0;
         end

         // Completed word is published one cycle after the wrapping sample
         if (r_wrap_d) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
         end

         if (w_end) begin
            r_abort    <= (r_bit_cnt != '0);
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_tx_armed <= 1'b0;
            r_ur_pend  <= 1'b0;
         end else begin
            if (w_do_sample) begin
               r_rx_shift <= w_rx_nxt;
               r_bit_cnt  <= r_bit_cnt + CW'(1);
            end

            // r_tx_armed gates the shift edge. With CPHA=0 the first bit is
            // already on the line after the load, and the trailing edge that
            // follows the last sample of the previous word must not advance
            // the freshly loaded word. With CPHA=1 the first shift edge only
            // presents the first bit.
            if (w_load) begin
               r_tx_shift <= r_hold_valid ? r_hold : '0;
               r_bit_cnt  <= '0;
               r_tx_armed <= 1'b0;
            end else if (w_in_shift) begin
               if (CPHA == 0) begin
                  if (w_sample) begin
                     r_tx_armed <= 1'b1;
                  end
                  if (w_shift && r_tx_armed) begin
                     r_tx_shift <= w_tx_adv;
                  end
               end else if (w_shift) begin
                  if (r_tx_armed) begin
                     r_tx_shift <= w_tx_adv;
                  end else begin
                     r_tx_armed <= 1'b1;
                  end
               end
            end

            // A word loaded at a boundary has only started once the next
            // leading edge arrives; if CS rises first it never ran, so the
            // empty-holding report waits for that edge.
            if (w_wrap && !r_hold_valid) begin
               r_ur_pend <= 1'b1;
            end else if (w_in_shift && w_lead) begin
               r_ur_pend <= 1'b0;
            end
         end
      end
   end

   assign spi_miso = (r_state == ST_SHIFT) && ((CPHA == 0) || r_tx_armed) ? w_tx_bit : 1'b0;
   assign tx_ready = ~r_hold_valid;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign busy     = (r_state == ST_SHIFT);
   assign underrun = (w_start & ~r_hold_valid) | (r_ur_pend & w_in_shift & w_lead);
   assign abort    = r_abort;

endmodule

// File: tb/tb_spi_target_core.sv
// tb/tb_spi_target_core.sv - self-checking bench for spi_target_core in several modes

module tb_spi_target_core;

   localparam int HALF = 8;   // SCK half period in clk cycles

   logic clk = 1'b0;
   logic rst;
   logic sclk [5];
   logic csn  [5];
   logic mosi [5];
   logic miso [5];
   logic txv  [5];
   logic txr  [5];
   logic rxv  [5];
   logic bsy  [5];
   logic ur   [5];
   logic ab   [5];
   logic [31:0] txd0, rxd0;
   logic [7:0]  txd8 [1:4];
   logic [7:0]  rxd8 [1:4];

   int n_chk = 0;
   int n_fail = 0;
   int rxv_cnt [5] = '{default: 0};
   int ur_cnt  [5] = '{default: 0};
   int ab_cnt  [5] = '{default: 0};
   logic p_rxv [5] = '{default: 1'b0};
   logic p_ur  [5] = '{default: 1'b0};
   logic p_ab  [5] = '{default: 1'b0};
   int dbl_cnt = 0;
   logic [31:0] rx_q [$];
   int b_rxv, b_ur, b_ab;

   always #5 clk = ~clk;

   // DUT 0: mode 0, 32 bit, MSB first; DUT 1..3: modes 1..3, 8 bit; DUT 4: mode 0, 8 bit, LSB first
   spi_target_core #(.WIDTH(32), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_d0 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_cs_n(csn[0]), .spi_mosi(mosi[0]),
      .spi_miso(miso[0]), .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(txr[0]),
      .rx_data(rxd0), .rx_valid(rxv[0]), .busy(bsy[0]), .underrun(ur[0]), .abort(ab[0]));
   spi_target_core #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1)) u_d1 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_cs_n(csn[1]), .spi_mosi(mosi[1]),
      .spi_miso(miso[1]), .tx_data(txd8[1]), .tx_valid(txv[1]), .tx_ready(txr[1]),
      .rx_data(rxd8[1]), .rx_valid(rxv[1]), .busy(bsy[1]), .underrun(ur[1]), .abort(ab[1]));
   spi_target_core #(.WIDTH(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1)) u_d2 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[2]), .spi_cs_n(csn[2]), .spi_mosi(mosi[2]),
      .spi_miso(miso[2]), .tx_data(txd8[2]), .tx_valid(txv[2]), .tx_ready(txr[2]),
      .rx_data(rxd8[2]), .rx_valid(rxv[2]), .busy(bsy[2]), .underrun(ur[2]), .abort(ab[2]));
   spi_target_core #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u_d3 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[3]), .spi_cs_n(csn[3]), .spi_mosi(mosi[3]),
      .spi_miso(miso[3]), .tx_data(txd8[3]), .tx_valid(txv[3]), .tx_ready(txr[3]),
      .rx_data(rxd8[3]), .rx_valid(rxv[3]), .busy(bsy[3]), .underrun(ur[3]), .abort(ab[3]));
   spi_target_core #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_d4 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[4]), .spi_cs_n(csn[4]), .spi_mosi(mosi[4]),
      .spi_miso(miso[4]), .tx_data(txd8[4]), .tx_valid(txv[4]), .tx_ready(txr[4]),
      .rx_data(rxd8[4]), .rx_valid(rxv[4]), .busy(bsy[4]), .underrun(ur[4]), .abort(ab[4]));

   // pulse counters and pulse-width watch
   always @(negedge clk) begin
      for (int d = 0; d < 5; d++) begin
         if (rxv[d]) rxv_cnt[d] <= rxv_cnt[d] + 1;
         if (ur[d])  ur_cnt[d]  <= ur_cnt[d] + 1;
         if (ab[d])  ab_cnt[d]  <= ab_cnt[d] + 1;
         if ((rxv[d] && p_rxv[d]) || (ur[d] && p_ur[d]) || (ab[d] && p_ab[d]))
            dbl_cnt <= dbl_cnt + 1;
         p_rxv[d] <= rxv[d];
         p_ur[d]  <= ur[d];
         p_ab[d]  <= ab[d];
      end
      if (rxv[0]) rx_q.push_back(rxd0);
   end

   function automatic bit cpol_of(input int d);
      return (d == 2) || (d == 3);
   endfunction

   function automatic bit cpha_of(input int d);
      return (d == 1) || (d == 3);
   endfunction

   function automatic int width_of(input int d);
      return (d == 0) ? 32 : 8;
   endfunction

   // wire-order bit i of a (possibly multi-word) stream -> position in the packed word buffer
   function automatic int bitpos(input int d, input int i);
      int w = width_of(d);
      return (i / w) * w + ((d == 4) ? (i % w) : (w - 1 - (i % w)));
   endfunction

   function automatic logic [63:0] rx_of(input int d);
      case (d)
         0:       return {32'h0, rxd0};
         1:       return {56'h0, rxd8[1]};
         2:       return {56'h0, rxd8[2]};
         3:       return {56'h0, rxd8[3]};
         default: return {56'h0, rxd8[4]};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap(input int d);
      b_rxv = rxv_cnt[d];
      b_ur  = ur_cnt[d];
      b_ab  = ab_cnt[d];
   endtask

   task automatic set_tx(input int d, input logic [63:0] w);
      if (d == 0) txd0 = w[31:0];
      else        txd8[d] = w[7:0];
      txv[d] = 1'b1;
      wclk(1);
      txv[d] = 1'b0;
   endtask

   task automatic preload(input int d, input logic [63:0] w);
      int t = 0;
      while (!txr[d] && t < 64) begin
         wclk(1);
         t++;
      end
      chk($sformatf("d%0d_ready_before_write", d), {63'h0, txr[d]}, 64'h1);
      set_tx(d, w);
      chk($sformatf("d%0d_ready_after_write", d), {63'h0, txr[d]}, 64'h0);
   endtask

   // Behaves as an SPI controller for DUT d; returns the bits seen on miso
   task automatic frame(input int d, input int nbits, input logic [63:0] mo,
                        input bit refill, input logic [63:0] rw, input bit keep_cs,
                        output logic [63:0] mi);
      bit cp = cpol_of(d);
      bit ch = cpha_of(d);
      mi = '0;
      csn[d] = 1'b0;
      if (!ch) mosi[d] = mo[bitpos(d, 0)];
      wclk(HALF);
      if (refill) set_tx(d, rw);
      for (int i = 0; i < nbits; i++) begin
         if (!ch) begin
            mi[bitpos(d, i)] = miso[d];
            sclk[d] = ~cp;
            wclk(HALF);
            sclk[d] = cp;
            if (i + 1 < nbits) mosi[d] = mo[bitpos(d, i + 1)];
            wclk(HALF);
         end else begin
            sclk[d] = ~cp;
            mosi[d] = mo[bitpos(d, i)];
            wclk(HALF);
            mi[bitpos(d, i)] = miso[d];
            sclk[d] = cp;
            wclk(HALF);
         end
         if (i == 1) chk($sformatf("d%0d_busy_mid", d), {63'h0, bsy[d]}, 64'h1);
      end
      if (!keep_cs) begin
         csn[d] = 1'b1;
         wclk(2 * HALF);
      end
   endtask

   logic [63:0] mi, pre, snd, w0, last_rx0;
   bit have_pre;

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 5; d++) begin
         csn[d] = 1'b1;
         sclk[d] = cpol_of(d);
         mosi[d] = 1'b0;
         txv[d] = 1'b0;
      end
      txd0 = '0;
      for (int d = 1; d < 5; d++) txd8[d] = '0;
      wclk(4);

      // values held under reset
      chk("rst_miso",     {63'h0, miso[0]}, 64'h0);
      chk("rst_tx_ready", {63'h0, txr[0]},  64'h1);
      chk("rst_rx_data",  rx_of(0),         64'h0);
      chk("rst_rx_valid", {63'h0, rxv[0]},  64'h0);
      chk("rst_busy",     {63'h0, bsy[0]},  64'h0);
      chk("rst_underrun", {63'h0, ur[0]},   64'h0);
      chk("rst_abort",    {63'h0, ab[0]},   64'h0);
      rst = 1'b0;
      wclk(6);
      chk("idle_busy", {63'h0, bsy[0]},  64'h0);
      chk("idle_miso", {63'h0, miso[0]}, 64'h0);

      // mode 0, 32 bit directed word
      preload(0, 64'hA5A50F0F);
      snap(0);
      frame(0, 32, 64'h12345678, 1'b0, 64'h0, 1'b0, mi);
      chk("m0_miso",     mi,                      64'hA5A50F0F);
      chk("m0_rx_data",  rx_of(0),                64'h12345678);
      chk("m0_rx_valid", 64'(rxv_cnt[0] - b_rxv), 64'd1);
      chk("m0_underrun", 64'(ur_cnt[0] - b_ur),   64'd0);
      chk("m0_abort",    64'(ab_cnt[0] - b_ab),   64'd0);

      // 8-bit modes 1..3 and LSB-first, directed then random words
      for (int r = 0; r < 3; r++) begin
         for (int d = 1; d < 5; d++) begin
            pre = (r == 0) ? 64'h3C : 64'($urandom_range(0, 255));
            snd = (r == 0) ? 64'hC3 : 64'($urandom_range(0, 255));
            preload(d, pre);
            snap(d);
            frame(d, 8, snd, 1'b0, 64'h0, 1'b0, mi);
            chk($sformatf("d%0d_r%0d_miso", d, r),     mi,                      pre);
            chk($sformatf("d%0d_r%0d_rx_data", d, r),  rx_of(d),                snd);
            chk($sformatf("d%0d_r%0d_rx_valid", d, r), 64'(rxv_cnt[d] - b_rxv), 64'd1);
            chk($sformatf("d%0d_r%0d_underrun", d, r), 64'(ur_cnt[d] - b_ur),   64'd0);
         end
      end

      // two words under one CS, holding refilled after the first load
      w0  = 64'($urandom);
      snd = {32'($urandom), 32'($urandom)};
      preload(0, w0);
      snap(0);
      rx_q.delete();
      frame(0, 64, snd, 1'b1, 64'hDEADBEEF, 1'b0, mi);
      chk("b2b_miso",     mi,                      {32'hDEADBEEF, w0[31:0]});
      chk("b2b_rx_valid", 64'(rxv_cnt[0] - b_rxv), 64'd2);
      chk("b2b_underrun", 64'(ur_cnt[0] - b_ur),   64'd0);
      chk("b2b_words",    64'(rx_q.size()),        64'd2);
      if (rx_q.size() == 2) begin
         chk("b2b_word0", {32'h0, rx_q[0]}, {32'h0, snd[31:0]});
         chk("b2b_word1", {32'h0, rx_q[1]}, {32'h0, snd[63:32]});
      end

      // no preload: underrun at frame start, zeros out, rx still captured
      snd = 64'($urandom);
      snap(0);
      frame(0, 32, snd, 1'b0, 64'h0, 1'b0, mi);
      chk("ur_miso",     mi,                      64'h0);
      chk("ur_underrun", 64'(ur_cnt[0] - b_ur),   64'd1);
      chk("ur_rx_data",  rx_of(0),                snd);
      chk("ur_rx_valid", 64'(rxv_cnt[0] - b_rxv), 64'd1);
      last_rx0 = snd;

      // CS raised after 13 of 32 bits
      pre = 64'($urandom);
      preload(0, pre);
      snap(0);
      frame(0, 13, 64'($urandom), 1'b0, 64'h0, 1'b0, mi);
      chk("abort_pulse",    64'(ab_cnt[0] - b_ab),   64'd1);
      chk("abort_rx_valid", 64'(rxv_cnt[0] - b_rxv), 64'd0);
      chk("abort_rx_held",  rx_of(0),                last_rx0);
      chk("abort_miso_top", {51'h0, mi[31:19]},      {51'h0, pre[31:19]});
      pre = 64'($urandom);
      snd = 64'($urandom);
      preload(0, pre);
      snap(0);
      frame(0, 32, snd, 1'b0, 64'h0, 1'b0, mi);
      chk("post_abort_miso",  mi,                    pre);
      chk("post_abort_rx",    rx_of(0),              snd);
      chk("post_abort_clean", 64'(ab_cnt[0] - b_ab), 64'd0);

      // reset after bit 20 with CS still low
      preload(0, 64'($urandom));
      snap(0);
      frame(0, 20, 64'($urandom), 1'b0, 64'h0, 1'b1, mi);
      rst = 1'b1;
      wclk(2);
      chk("mid_rst_miso",     {63'h0, miso[0]}, 64'h0);
      chk("mid_rst_tx_ready", {63'h0, txr[0]},  64'h1);
      chk("mid_rst_rx_data",  rx_of(0),         64'h0);
      chk("mid_rst_rx_valid", {63'h0, rxv[0]},  64'h0);
      chk("mid_rst_busy",     {63'h0, bsy[0]},  64'h0);
      chk("mid_rst_underrun", {63'h0, ur[0]},   64'h0);
      chk("mid_rst_abort",    {63'h0, ab[0]},   64'h0);
      rst = 1'b0;
      wclk(10);
      chk("post_rst_no_frame", {63'h0, bsy[0]}, 64'h0);
      csn[0] = 1'b1;
      wclk(2 * HALF);
      chk("post_rst_no_rx", 64'(rxv_cnt[0] - b_rxv), 64'd0);
      chk("post_rst_no_ab", 64'(ab_cnt[0] - b_ab),   64'd0);
      pre = 64'($urandom);
      snd = 64'($urandom);
      preload(0, pre);
      snap(0);
      frame(0, 32, snd, 1'b0, 64'h0, 1'b0, mi);
      chk("post_rst_miso",     mi,                      pre);
      chk("post_rst_rx",       rx_of(0),                snd);
      chk("post_rst_rx_valid", 64'(rxv_cnt[0] - b_rxv), 64'd1);

      // random single-word frames, with or without preload
      for (int k = 0; k < 4; k++) begin
         have_pre = 1'($urandom_range(0, 1));
         pre = 64'($urandom);
         snd = 64'($urandom);
         if (have_pre) preload(0, pre);
         snap(0);
         frame(0, 32, snd, 1'b0, 64'h0, 1'b0, mi);
         chk($sformatf("rnd%0d_miso", k),     mi,                      have_pre ? pre : 64'h0);
         chk($sformatf("rnd%0d_rx", k),       rx_of(0),                snd);
         chk($sformatf("rnd%0d_underrun", k), 64'(ur_cnt[0] - b_ur),   have_pre ? 64'd0 : 64'd1);
         chk($sformatf("rnd%0d_rx_valid", k), 64'(rxv_cnt[0] - b_rxv), 64'd1);
      end

      wclk(4);
      chk("pulse_width", 64'(dbl_cnt), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
